countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 14 +
 rtl/countdown_timer.sv | 107 ++++++++++
 tb/tb_countdown_timer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer.
//   state_t       : controller state (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default bit width of the load value and count
package countdown_timer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/resume, optional auto-reload and a
// one-cycle expiry pulse.
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   load        : capture val into count and the reload register, go IDLE
//   val         : load value
//   start       : begin or resume counting
//   stop        : pause counting (wins over start)
//   auto_reload : on expiry reload from the reload register instead of halting
//   count       : current count (registered)
//   expired     : registered one-cycle pulse on terminal count
//   busy        : high while counting (registered copy of state == RUN)
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             expired,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] reload_q;

    // Controller: priority rst > load > stop > start; busy tracks every state write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            reload_q <= '0;
            expired  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                // A load also swallows a terminal count in the same cycle.
                count    <= val;
                reload_q <= val;
                state    <= IDLE;
                busy     <= 1'b0;
            end else if (stop) begin
                // Pausing holds the count; stop outside RUN changes nothing.
                if (state == RUN) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            if (count != '0) begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end else if (reload_q != '0) begin
                                count <= reload_q;
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else if (count == WIDTH'(1)) begin
                            // Terminal count: zero is skipped when reloading.
                            expired <= 1'b1;
                            if (auto_reload) begin
                                count <= reload_q;
                            end else begin
                                count <= '0;
                                state <= DONE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            // Unreachable with a consistent reload register; never wrap.
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Invariants for the formal flow; also checked in simulation.
    a_count_le_reload : assert property (@(posedge clk) disable iff (rst)
        (state == RUN) |-> (count <= reload_q));

    a_expired_origin : assert property (@(posedge clk) disable iff (rst)
        expired |-> (($past(state) == RUN) && ($past(count) == WIDTH'(1))));

    a_busy_is_run : assert property (@(posedge clk) disable iff (rst)
        busy == (state == RUN));

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenario tables plus a
// randomized run checked against a behavioural model.
module tb_countdown_timer;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic         r;
        logic         l;
        logic [W-1:0] v;
        logic         s;
        logic         p;
        logic         a;
        logic [W-1:0] c;
        logic         b;
        logic         e;
    } step_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] val = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] count;
    logic         expired;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;

    countdown_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .val         (val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .expired     (expired),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; val = 4'd9; start = 1'b1; stop = 1'b0; auto_reload = 1'b0;
        tick();
        tick();
        n_total++;
        if ({count, busy, expired} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset: count=%0d busy=%0b expired=%0b, expected 0 0 0", count, busy, expired);
        else n_pass++;
        rst = 1'b0; load = 1'b0; start = 1'b0;
        tick();
        n_total++;
        if ({count, busy, expired} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_release: count=%0d busy=%0b expired=%0b, expected 0 0 0", count, busy, expired);
        else n_pass++;
    endtask

    // fields: r l v s p a | count busy expired
    task automatic test_load_countdown();
        step_t st [6];
        st = '{
            '{1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL load_countdown step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_auto_reload();
        step_t st [13];
        st = '{
            '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL auto_reload step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_pause_resume();
        step_t st [13];
        st = '{
            '{1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL pause_resume step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        step_t st [8];
        st = '{
            '{1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL simultaneous step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        step_t st [8];
        st = '{
            '{1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd9, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0},
            '{1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL reset_mid step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_restart();
        step_t st [13];
        st = '{
            '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
            '{1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
            '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0},
            '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0}
        };
        foreach (st[i]) begin
            rst = st[i].r; load = st[i].l; val = st[i].v;
            start = st[i].s; stop = st[i].p; auto_reload = st[i].a;
            tick();
            n_total++;
            if ({count, busy, expired} !== {st[i].c, st[i].b, st[i].e})
                $display("FAIL zero_restart step %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         i, count, busy, expired, st[i].c, st[i].b, st[i].e);
            else n_pass++;
        end
    endtask

    // Randomized run against a behavioural model: a running flag, a count and
    // a remembered load value, updated from the timer's rules each cycle.
    task automatic test_random();
        int  m_count  = 0;
        int  m_reload = 0;
        bit  m_run    = 0;
        bit  m_exp    = 0;
        int  v;
        for (int n = 0; n < 600; n++) begin
            rst         = (n == 0) || ($urandom_range(0, 99) < 2);
            load        = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       v = 0;
                1:       v = 1;
                2:       v = 2;
                default: v = int'($urandom_range(0, 15));
            endcase
            val         = W'(v);
            start       = ($urandom_range(0, 99) < 35);
            stop        = ($urandom_range(0, 99) < 8);
            auto_reload = $urandom_range(0, 1) == 1;

            m_exp = 0;
            if (rst) begin
                m_count = 0; m_reload = 0; m_run = 0;
            end else if (load) begin
                m_count = v; m_reload = v; m_run = 0;
            end else if (stop) begin
                m_run = 0;
            end else if (!m_run) begin
                if (start && m_count != 0) begin
                    m_run = 1;
                end else if (start && m_reload != 0) begin
                    m_count = m_reload; m_run = 1;
                end
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_exp = 1;
                if (auto_reload) m_count = m_reload;
                else begin
                    m_count = 0; m_run = 0;
                end
            end

            tick();
            n_total++;
            if ({count, busy, expired} !== {W'(m_count), m_run, m_exp})
                $display("FAIL random cycle %0d: count=%0d busy=%0b expired=%0b, expected %0d %0b %0b",
                         n, count, busy, expired, m_count, m_run, m_exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_load_countdown();
        test_auto_reload();
        test_pause_resume();
        test_simultaneous();
        test_reset_mid();
        test_zero_restart();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
